// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-product vending machine.
// Coin encodings, FSM state type and default parameter values.
package vending_pkg;

    localparam int PRICE_N_DEF  = 3;
    localparam int MAX_N_DEF    = 7;
    localparam int NUM_PROD_DEF = 4;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE
    } state_t;

endpackage

// File: rtl/vm_coin_value.sv
// Combinational decode of a coin code into its value in nickels.
module vm_coin_value
    import vending_pkg::*;
(
    input  logic [1:0] coin,
    output logic [2:0] value
);

    always_comb begin
        value = '0;
        unique case (coin)
            COIN_NICKEL:  value = 3'd1;
            COIN_DIME:    value = 3'd2;
            COIN_QUARTER: value = 3'd5;
            default:      value = '0;
        endcase
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin credit, product vend and nickel-by-nickel change.
// Moore FSM; every output is a register updated from the next-state decode.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter  int PRICE_N  = PRICE_N_DEF,
    parameter  int MAX_N    = MAX_N_DEF,
    parameter  int NUM_PROD = NUM_PROD_DEF,
    localparam int PROD_W   = $clog2(NUM_PROD),
    localparam int CREDIT_W = $clog2(MAX_N + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [PROD_W-1:0]   sel,
    input  logic                cancel,
    output logic                dispense,
    output logic [PROD_W-1:0]   dispense_id,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int SUM_W = CREDIT_W + 3;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [PROD_W-1:0]   id_n;
    logic                reject_n;
    logic [2:0]          coin_val;
    logic [SUM_W-1:0]    sum;
    logic                coin_fits;
    logic                sel_ok;
    logic                can_pay;

    vm_coin_value u_coin_value (
        .coin  (coin),
        .value (coin_val)
    );

    assign sum       = SUM_W'(credit) + SUM_W'(coin_val);
    assign coin_fits = (sum <= SUM_W'(MAX_N));
    assign sel_ok    = ({1'b0, sel} < (PROD_W + 1)'(NUM_PROD));
    assign can_pay   = (credit >= CREDIT_W'(PRICE_N));

    // Priority while accepting: coin, then cancel, then selection.
    always_comb begin
        state_n  = state;
        credit_n = credit;
        id_n     = dispense_id;
        reject_n = 1'b0;
        unique case (state)
            ST_IDLE, ST_COLLECT: begin
                if (coin != COIN_NONE) begin
                    if (coin_fits) begin
                        credit_n = sum[CREDIT_W-1:0];
                        state_n  = ST_COLLECT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end else if (cancel) begin
                    if (state == ST_COLLECT) state_n = ST_CHANGE;
                end else if (sel_valid && state == ST_COLLECT && can_pay && sel_ok) begin
                    credit_n = credit - CREDIT_W'(PRICE_N);
                    id_n     = sel;
                    state_n  = ST_VEND;
                end
            end
            ST_VEND: begin
                reject_n = (coin != COIN_NONE);
                state_n  = (credit != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                reject_n = (coin != COIN_NONE);
                if (credit != '0) credit_n = credit - 1'b1;
                if (credit <= CREDIT_W'(1)) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            credit        <= '0;
            dispense_id   <= '0;
            coin_reject   <= 1'b0;
            dispense      <= 1'b0;
            change_nickel <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            credit        <= credit_n;
            dispense_id   <= id_n;
            coin_reject   <= reject_n;
            dispense      <= (state_n == ST_VEND);
            change_nickel <= (state_n == ST_CHANGE);
            busy          <= (state_n == ST_VEND) || (state_n == ST_CHANGE);
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: an output-schedule model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vending_machine_multi;

    localparam int PRICE_N  = 3;
    localparam int MAX_N    = 7;
    localparam int NUM_PROD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       dispense;
    logic [1:0] dispense_id;
    logic       change_nickel;
    logic       coin_reject;
    logic       busy;
    logic [2:0] credit;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 0;

    always #5 clock = ~clock;

    vending_machine_multi #(
        .PRICE_N  (PRICE_N),
        .MAX_N    (MAX_N),
        .NUM_PROD (NUM_PROD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .coin          (coin),
        .sel_valid     (sel_valid),
        .sel           (sel),
        .cancel        (cancel),
        .dispense      (dispense),
        .dispense_id   (dispense_id),
        .change_nickel (change_nickel),
        .coin_reject   (coin_reject),
        .busy          (busy),
        .credit        (credit)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the output record of the current cycle plus a queue of scheduled
    // records for a vend/change sequence already committed.
    typedef struct {
        bit disp;
        bit chg;
        int cr;
    } rec_t;

    rec_t cur = '{0, 0, 0};
    rec_t sched[$];
    int   m_id  = 0;
    bit   m_rej = 0;

    always @(posedge clock) begin
        int  v;
        int  c;
        bit  locked;
        v = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : (coin == 2'b11) ? 5 : 0;
        locked = cur.disp || cur.chg;
        if (!reset) begin
            sched.delete();
            cur   = '{0, 0, 0};
            m_id  = 0;
            m_rej = 0;
        end else begin
            m_rej = (v != 0) && (locked || (cur.cr + v > MAX_N));
            if (locked) begin
                if (sched.size() > 0) cur = sched.pop_front();
                else                  cur = '{0, 0, 0};
            end else if (v != 0) begin
                if (!m_rej) cur.cr = cur.cr + v;
            end else if (cancel && cur.cr > 0) begin
                c = cur.cr;
                cur = '{0, 1, c};
                for (int k = c - 1; k >= 1; k--) sched.push_back('{0, 1, k});
            end else if (sel_valid && cur.cr >= PRICE_N && int'(sel) < NUM_PROD) begin
                m_id = int'(sel);
                c = cur.cr - PRICE_N;
                cur = '{1, 0, c};
                for (int k = c; k >= 1; k--) sched.push_back('{0, 1, k});
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            chk("model.dispense",      int'(dispense),      int'(cur.disp));
            chk("model.change_nickel", int'(change_nickel), int'(cur.chg));
            chk("model.busy",          int'(busy),          int'(cur.disp || cur.chg));
            chk("model.credit",        int'(credit),        cur.cr);
            chk("model.coin_reject",   int'(coin_reject),   int'(m_rej));
            chk("model.dispense_id",   int'(dispense_id),   m_id);
        end
    end

    // Apply one cycle of inputs, then return at the following negedge with
    // the post-edge outputs settled.
    task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] s,
                       input logic cn, input logic rn);
        coin = c; sel_valid = sv; sel = s; cancel = cn; reset = rn;
        @(negedge clock);
        coin = 2'b00; sel_valid = 1'b0; cancel = 1'b0; reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        coin = 2'b00; sel_valid = 1'b0; sel = 2'b00; cancel = 1'b0; reset = 1'b0;
        @(negedge clock);
        cyc(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        checking = 1;
        chk("reset.credit", int'(credit), 0);
        chk("reset.busy",   int'(busy),   0);

        // Nickel + dime, select product 2: exact payment, no change.
        cyc(2'b01, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("s1.credit_after_nickel", int'(credit), 1);
        cyc(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("s1.credit_after_dime", int'(credit), 3);
        cyc(2'b00, 1'b1, 2'd2, 1'b0, 1'b1);
        chk("s1.dispense", int'(dispense), 1);
        chk("s1.dispense_id", int'(dispense_id), 2);
        chk("s1.credit_vend", int'(credit), 0);
        idle(1);
        chk("s1.dispense_done", int'(dispense), 0);
        chk("s1.no_change", int'(change_nickel), 0);
        chk("s1.idle_busy", int'(busy), 0);

        // Quarter, select product 1: two nickels back; a coin during VEND bounces.
        cyc(2'b11, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("s2.credit", int'(credit), 5);
        cyc(2'b00, 1'b1, 2'd1, 1'b0, 1'b1);
        chk("s2.dispense", int'(dispense), 1);
        chk("s2.busy_vend", int'(busy), 1);
        chk("s2.credit_vend", int'(credit), 2);
        cyc(2'b01, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("s2.reject_in_vend", int'(coin_reject), 1);
        chk("s2.change1", int'(change_nickel), 1);
        chk("s2.credit_c1", int'(credit), 2);
        idle(1);
        chk("s2.change2", int'(change_nickel), 1);
        chk("s2.credit_c2", int'(credit), 1);
        idle(1);
        chk("s2.change_done", int'(change_nickel), 0);
        chk("s2.busy_done", int'(busy), 0);
        chk("s2.credit_done", int'(credit), 0);

        // Dime + quarter fills credit to 7; another nickel is rejected.
        cyc(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(2'b11, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("s3.credit_full", int'(credit), 7);
        cyc(2'b01, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("s3.reject", int'(coin_reject), 1);
        chk("s3.credit_held", int'(credit), 7);
        idle(1);
        chk("s3.reject_one_cycle", int'(coin_reject), 0);
        cyc(2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
        idle(8);
        chk("s3.refunded", int'(credit), 0);

        // Dime, underpaid selection ignored, cancel refunds two nickels.
        cyc(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(2'b00, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("s4.no_dispense", int'(dispense), 0);
        chk("s4.credit_kept", int'(credit), 2);
        cyc(2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
        chk("s4.change1", int'(change_nickel), 1);
        idle(1);
        chk("s4.change2", int'(change_nickel), 1);
        idle(1);
        chk("s4.change_done", int'(change_nickel), 0);
        chk("s4.id_held", int'(dispense_id), 1);

        // Credit 2, nickel with simultaneous select: coin wins; select next cycle vends.
        cyc(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(2'b01, 1'b1, 2'd3, 1'b0, 1'b1);
        chk("s5.credit_coin_wins", int'(credit), 3);
        chk("s5.no_dispense", int'(dispense), 0);
        cyc(2'b00, 1'b1, 2'd3, 1'b0, 1'b1);
        chk("s5.dispense", int'(dispense), 1);
        chk("s5.dispense_id", int'(dispense_id), 3);
        idle(2);

        // Cancel beats select; reset mid-CHANGE with credit 3 drops everything.
        cyc(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(2'b01, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(2'b00, 1'b1, 2'd1, 1'b1, 1'b1);
        chk("s6.cancel_wins", int'(dispense), 0);
        chk("s6.change", int'(change_nickel), 1);
        chk("s6.credit", int'(credit), 3);
        cyc(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("s6.rst_credit", int'(credit), 0);
        chk("s6.rst_change", int'(change_nickel), 0);
        chk("s6.rst_busy", int'(busy), 0);
        chk("s6.rst_id", int'(dispense_id), 0);
        chk("s6.rst_dispense", int'(dispense), 0);
        chk("s6.rst_reject", int'(coin_reject), 0);
        idle(3);
        chk("s6.no_more_change", int'(change_nickel), 0);
        chk("s6.idle_credit", int'(credit), 0);

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
